// File: rtl/bram_pkg.sv
// Shared types and helpers for the simple-dual-port byte-enable block RAM.
package bram_pkg;

  typedef enum logic {
    RDW_OLD = 1'b0,
    RDW_NEW = 1'b1
  } rdw_mode_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bram_state_t;

  function automatic int unsigned nb_bytes(input int unsigned data_w, input int unsigned byte_w);
    return data_w / byte_w;
  endfunction

endpackage

// File: rtl/bram_init_seq.sv
// Post-reset clear sequencer: walks every word once, then raises ready until the next reset.
module bram_init_seq
  import bram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 9,
  parameter int unsigned RAM_DEPTH     = 2**ADDR_WIDTH,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  ready_o,
  output logic                  init_we_o,
  output logic [ADDR_WIDTH-1:0] init_addr_o
);

  localparam bram_state_t           RST_STATE = INIT_ON_RESET ? INIT : RUN;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  bram_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ready_q, ready_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Sweep one word per cycle; the last word hands over to RUN in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = RUN;
          cnt_d   = '0;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        ready_d = 1'b1;
      end
      default: begin
        state_d = RST_STATE;
        cnt_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  assign ready_o     = ready_q;
  assign init_we_o   = (state_q == INIT);
  assign init_addr_o = cnt_q;

endmodule

// File: rtl/bram_sdp_be.sv
// Single-clock simple-dual-port RAM: byte-enable write port, pipelined read port (0..2 regs),
// selectable read-during-write result and optional post-reset clear sweep.
module bram_sdp_be
  import bram_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH    = 9,
  parameter int unsigned           RAM_DEPTH     = 2**ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH    = 32,
  parameter int unsigned           BYTE_WIDTH    = 8,
  parameter int unsigned           READ_NB_FFD   = 1,
  parameter rdw_mode_t             RDW_MODE      = RDW_OLD,
  parameter bit                    INIT_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  output logic                                           ready_o,
  input  logic                                           wren_i,
  input  logic [nb_bytes(DATA_WIDTH, BYTE_WIDTH)-1:0]    wrbe_i,
  input  logic [ADDR_WIDTH-1:0]                          wraddr_i,
  input  logic [DATA_WIDTH-1:0]                          wrdata_i,
  input  logic                                           rden_i,
  input  logic [ADDR_WIDTH-1:0]                          rdaddr_i,
  output logic [DATA_WIDTH-1:0]                          rddata_o,
  output logic                                           rdvalid_o
);

  localparam int unsigned NB_BYTES = nb_bytes(DATA_WIDTH, BYTE_WIDTH);
  localparam int unsigned MEM_AW   = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_err_dw
    $error("bram_sdp_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (READ_NB_FFD > 2) begin : g_err_ffd
    $error("bram_sdp_be: READ_NB_FFD must be 0, 1 or 2");
  end
  if (RAM_DEPTH > 2**ADDR_WIDTH) begin : g_err_depth
    $error("bram_sdp_be: RAM_DEPTH exceeds 2**ADDR_WIDTH");
  end

  logic                  ready;
  logic                  init_we;
  logic [ADDR_WIDTH-1:0] init_addr;

  bram_init_seq #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .RAM_DEPTH     (RAM_DEPTH),
    .INIT_ON_RESET (INIT_ON_RESET)
  ) u_init_seq (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ready_o     (ready),
    .init_we_o   (init_we),
    .init_addr_o (init_addr)
  );

  assign ready_o = ready;

  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

  logic                  wr_ok_c;
  logic                  rd_ok_c;
  logic                  rd_in_range_c;
  logic [DATA_WIDTH-1:0] rd_old_c;

  assign wr_ok_c       = ready & ~rst_i & wren_i & (32'(wraddr_i) < RAM_DEPTH);
  assign rd_ok_c       = ready & rden_i;
  assign rd_in_range_c = (32'(rdaddr_i) < RAM_DEPTH);
  assign rd_old_c      = rd_in_range_c ? mem_q[MEM_AW'(rdaddr_i)] : '0;

  logic                  mem_we_c;
  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic [NB_BYTES-1:0]   mem_be_c;
  logic [DATA_WIDTH-1:0] mem_wdata_c;

  // Clear sweep owns the write port until ready; afterwards only accepted user writes reach it.
  always_comb begin
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_be_c    = '0;
    mem_wdata_c = '0;
    if (!ready) begin
      if (init_we && !rst_i) begin
        mem_we_c    = 1'b1;
        mem_addr_c  = init_addr;
        mem_be_c    = '1;
        mem_wdata_c = INIT_VALUE;
      end
    end else if (wr_ok_c) begin
      mem_we_c    = 1'b1;
      mem_addr_c  = wraddr_i;
      mem_be_c    = wrbe_i;
      mem_wdata_c = wrdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we_c) begin
      for (int unsigned b = 0; b < NB_BYTES; b++) begin
        if (mem_be_c[b]) begin
          mem_q[MEM_AW'(mem_addr_c)][b*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata_c[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  if (READ_NB_FFD == 0) begin : g_ffd0
    // Combinational read always sees the array before this cycle's write lands.
    assign rddata_o  = rd_old_c;
    assign rdvalid_o = rd_ok_c;
  end else begin : g_pipe
    logic [DATA_WIDTH-1:0] rd_word_c;
    logic [DATA_WIDTH-1:0] s1_data_q;
    logic                  s1_vld_q;

    // RDW_NEW forwards the write bytes into a colliding read; RDW_OLD keeps the pre-write word.
    always_comb begin
      rd_word_c = rd_old_c;
      if ((RDW_MODE == RDW_NEW) && wr_ok_c && (wraddr_i == rdaddr_i)) begin
        for (int unsigned b = 0; b < NB_BYTES; b++) begin
          if (wrbe_i[b]) begin
            rd_word_c[b*BYTE_WIDTH +: BYTE_WIDTH] = wrdata_i[b*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        s1_vld_q  <= 1'b0;
        s1_data_q <= '0;
      end else begin
        s1_vld_q <= rd_ok_c;
        if (rd_ok_c) begin
          s1_data_q <= rd_word_c;
        end
      end
    end

    if (READ_NB_FFD == 1) begin : g_ffd1
      assign rddata_o  = s1_data_q;
      assign rdvalid_o = s1_vld_q;
    end else begin : g_ffd2
      logic [DATA_WIDTH-1:0] s2_data_q;
      logic                  s2_vld_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          s2_vld_q  <= 1'b0;
          s2_data_q <= '0;
        end else begin
          s2_vld_q <= s1_vld_q;
          if (s1_vld_q) begin
            s2_data_q <= s1_data_q;
          end
        end
      end

      assign rddata_o  = s2_data_q;
      assign rdvalid_o = s2_vld_q;
    end
  end

endmodule

// File: tb/tb_bram_sdp_be.sv
// Scoreboard bench for bram_sdp_be: three read-latency/RDW variants plus a no-init variant,
// all driven by the same stimulus and checked against an array model of the memory.
module tb_bram_sdp_be;
  import bram_pkg::*;

  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] INITV = 32'hC0DE_F00D;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wren, rden;
  logic [3:0]  wrbe;
  logic [4:0]  wraddr, rdaddr;
  logic [31:0] wrdata;

  logic        rdy [4];
  logic        rdv [4];
  logic [31:0] rdd [4];

  always #5 clk = ~clk;

  bram_sdp_be #(.ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .DATA_WIDTH(32), .BYTE_WIDTH(8),
                .READ_NB_FFD(0), .RDW_MODE(RDW_OLD), .INIT_ON_RESET(1'b1), .INIT_VALUE(INITV))
  u_ffd0 (.clk_i(clk), .rst_i(rst), .ready_o(rdy[0]), .wren_i(wren), .wrbe_i(wrbe),
          .wraddr_i(wraddr), .wrdata_i(wrdata), .rden_i(rden), .rdaddr_i(rdaddr),
          .rddata_o(rdd[0]), .rdvalid_o(rdv[0]));

  bram_sdp_be #(.ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .DATA_WIDTH(32), .BYTE_WIDTH(8),
                .READ_NB_FFD(1), .RDW_MODE(RDW_NEW), .INIT_ON_RESET(1'b1), .INIT_VALUE(INITV))
  u_ffd1 (.clk_i(clk), .rst_i(rst), .ready_o(rdy[1]), .wren_i(wren), .wrbe_i(wrbe),
          .wraddr_i(wraddr), .wrdata_i(wrdata), .rden_i(rden), .rdaddr_i(rdaddr),
          .rddata_o(rdd[1]), .rdvalid_o(rdv[1]));

  bram_sdp_be #(.ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .DATA_WIDTH(32), .BYTE_WIDTH(8),
                .READ_NB_FFD(2), .RDW_MODE(RDW_OLD), .INIT_ON_RESET(1'b1), .INIT_VALUE(INITV))
  u_ffd2 (.clk_i(clk), .rst_i(rst), .ready_o(rdy[2]), .wren_i(wren), .wrbe_i(wrbe),
          .wraddr_i(wraddr), .wrdata_i(wrdata), .rden_i(rden), .rdaddr_i(rdaddr),
          .rddata_o(rdd[2]), .rdvalid_o(rdv[2]));

  bram_sdp_be #(.ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .DATA_WIDTH(32), .BYTE_WIDTH(8),
                .READ_NB_FFD(1), .RDW_MODE(RDW_OLD), .INIT_ON_RESET(1'b0), .INIT_VALUE(INITV))
  u_noinit (.clk_i(clk), .rst_i(rst), .ready_o(rdy[3]), .wren_i(wren), .wrbe_i(wrbe),
            .wraddr_i(wraddr), .wrdata_i(wrdata), .rden_i(rden), .rdaddr_i(rdaddr),
            .rddata_o(rdd[3]), .rdvalid_o(rdv[3]));

  logic [31:0] model_mem [DEPTH];
  exp_t        sbq [3][$];
  logic [31:0] last_d [3];
  int unsigned cyc = 0;
  int          rel = 0;
  int          errors = 0;
  int          checks = 0;
  bit          mon_en = 1'b0;
  bit          iss3 = 1'b0;
  bit          exp3 = 1'b0;
  bit          done = 1'b0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~mask) | (wd & mask);
  endfunction

  // One clock of stimulus; expected read results are queued at issue time.
  task automatic step(input logic we, input logic [3:0] be, input logic [4:0] wa,
                      input logic [31:0] wd, input logic re, input logic [4:0] ra);
    exp_t        e;
    logic [31:0] old_w, new_w;
    bit          rdy_m;
    wren = we; wrbe = be; wraddr = wa; wrdata = wd; rden = re; rdaddr = ra;
    rdy_m = (rel >= int'(DEPTH));
    iss3  = (rel >= 1) && re;
    if (rdy_m && re) begin
      old_w = (int'(ra) < int'(DEPTH)) ? model_mem[ra[3:0]] : 32'h0;
      new_w = (we && wa == ra && int'(ra) < int'(DEPTH)) ? merge(old_w, wd, be) : old_w;
      e.data = old_w; e.due = cyc;     sbq[0].push_back(e);
      e.data = new_w; e.due = cyc + 1; sbq[1].push_back(e);
      e.data = old_w; e.due = cyc + 2; sbq[2].push_back(e);
    end
    if (rdy_m && we && int'(wa) < int'(DEPTH)) begin
      model_mem[wa[3:0]] = merge(model_mem[wa[3:0]], wd, be);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 5'd0, 32'h0, 1'b0, 5'd0);
  endtask

  // Monitor: track reset/cycle at the edge, compare outputs on the falling edge.
  always begin
    @(posedge clk);
    cyc = cyc + 1;
    exp3 = iss3;
    if (rst) begin
      rel = 0;
      for (int d = 0; d < 3; d++) last_d[d] = 32'h0;
    end else if (rel < 1000) begin
      rel = rel + 1;
    end
    @(negedge clk);
    if (mon_en && !done) begin
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (rdy[d] !== (rel >= int'(DEPTH))) begin
          errors++;
          $display("FAIL ready dut%0d cyc=%0d: got %b expected %b", d, cyc, rdy[d], rel >= int'(DEPTH));
        end
      end
      checks++;
      if (rdy[3] !== (rel >= 1)) begin
        errors++;
        $display("FAIL ready_noinit cyc=%0d: got %b expected %b", cyc, rdy[3], rel >= 1);
      end
      checks++;
      if (rdv[3] !== exp3) begin
        errors++;
        $display("FAIL rdvalid_noinit cyc=%0d: got %b expected %b", cyc, rdv[3], exp3);
      end
      for (int d = 0; d < 3; d++) begin
        if (rdv[d] === 1'b1) begin
          checks++;
          if (sbq[d].size() == 0) begin
            errors++;
            $display("FAIL unexpected_rdvalid dut%0d cyc=%0d: got rddata %h expected no beat", d, cyc, rdd[d]);
          end else begin
            exp_t e;
            e = sbq[d].pop_front();
            if (rdd[d] !== e.data || cyc != e.due) begin
              errors++;
              $display("FAIL read_beat dut%0d: got %h at cyc %0d expected %h at cyc %0d", d, rdd[d], cyc, e.data, e.due);
            end
            last_d[d] = e.data;
          end
        end else begin
          if (sbq[d].size() != 0 && sbq[d][0].due <= cyc) begin
            exp_t e;
            e = sbq[d].pop_front();
            checks++;
            errors++;
            $display("FAIL missing_rdvalid dut%0d cyc=%0d: got rdvalid 0 expected beat %h", d, cyc, e.data);
          end
          if (d > 0) begin
            checks++;
            if (rdd[d] !== last_d[d]) begin
              errors++;
              $display("FAIL rddata_hold dut%0d cyc=%0d: got %h expected %h", d, cyc, rdd[d], last_d[d]);
            end
          end
        end
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b1; wren = 1'b0; rden = 1'b0; wrbe = 4'h0; wraddr = 5'd0; rdaddr = 5'd0; wrdata = 32'h0;
    for (int d = 0; d < 3; d++) last_d[d] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = INITV;

    // Release reset, then pull it again seven cycles into the sweep.
    rst = 1'b0;
    guard = 0;
    while (rel < 7 && guard < 50) begin idle(1); guard++; end
    rst = 1'b1;
    idle(1);
    rst = 1'b0;

    // Port activity while not ready must be ignored.
    step(1'b1, 4'hF, 5'd2, 32'hDEAD_BEEF, 1'b1, 5'd2);
    step(1'b0, 4'h0, 5'd0, 32'h0,         1'b1, 5'd9);
    step(1'b1, 4'hF, 5'd7, 32'h0BAD_0BAD, 1'b0, 5'd0);
    guard = 0;
    while (rel < int'(DEPTH) && guard < 100) begin idle(1); guard++; end
    checks++;
    if (rel < int'(DEPTH)) begin
      errors++;
      $display("FAIL sweep_timeout: got rel %0d expected %0d", rel, DEPTH);
    end

    // Whole array reads back the clear value.
    for (int a = 0; a < int'(DEPTH); a++) step(1'b0, 4'h0, 5'd0, 32'h0, 1'b1, 5'(a));
    idle(3);

    // Byte-enable merge on address 5.
    step(1'b1, 4'hF, 5'd5, 32'hAABB_CCDD, 1'b0, 5'd0);
    step(1'b1, 4'h5, 5'd5, 32'h1122_3344, 1'b0, 5'd0);
    step(1'b0, 4'h0, 5'd0, 32'h0,         1'b1, 5'd5);
    idle(3);

    // Read-during-write on address 3.
    step(1'b1, 4'hF, 5'd3, 32'h0,         1'b0, 5'd0);
    step(1'b1, 4'h3, 5'd3, 32'hFFFF_FFFF, 1'b1, 5'd3);
    step(1'b0, 4'h0, 5'd0, 32'h0,         1'b1, 5'd3);
    idle(3);

    // Back-to-back burst then hold.
    for (int a = 0; a < 8; a++) step(1'b0, 4'h0, 5'd0, 32'h0, 1'b1, 5'(a));
    idle(5);

    // Out-of-range write/read and alias checks.
    step(1'b1, 4'hF, 5'd20, 32'h1234_5678, 1'b1, 5'd20);
    step(1'b1, 4'hF, 5'd31, 32'h8765_4321, 1'b1, 5'd4);
    step(1'b0, 4'h0, 5'd0,  32'h0,         1'b1, 5'd15);
    idle(3);

    // Randomised traffic with frequent address collisions.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] wa, ra;
      wa = 5'($urandom_range(0, 19));
      ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 19));
      step(1'($urandom_range(0, 1)), 4'($urandom), wa, $urandom,
           ($urandom_range(0, 9) < 7), ra);
    end
    idle(6);

    done = 1'b1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (sbq[d].size() != 0) begin
        errors++;
        $display("FAIL drain dut%0d: got %0d pending expected 0", d, sbq[d].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    checks++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
